// File: rtl/motor_loop_sched.sv
// motor_loop_sched: periodic proportional position loop for NCH motor channels.
// A free-running timer issues a tick every PERIOD clocks. Each tick starts a
// sweep that pushes every channel, one after another, through a single shared
// datapath: err = sat(setpoint - position), prod = err * kp,
// duty = sat((prod >>> SHIFT) + midpoint).
// Each channel spends three cycles in the sweep (LOAD, MUL, WRITE), so only one
// multiply is ever in flight.
//
// Config port: cfg_we is a single-cycle write strobe with no handshake. The
// write lands in the register on the next clock edge. Address 4'hF always
// clears overrun, so with NCH=8 the slot that would hold kp[7] is unreachable.
module motor_loop_sched #(
  parameter int NCH    = 3,
  parameter int ENC_W  = 16,
  parameter int PWM_W  = 8,
  parameter int GAIN_W = 8,
  parameter int SHIFT  = 4,
  parameter int PERIOD = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCH*ENC_W-1:0]   enc_count,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [15:0]            cfg_wdata,
  output logic [NCH*PWM_W-1:0]   duty,
  output logic [NCH-1:0]         duty_stb,
  output logic                   busy,
  output logic                   overrun
);

  localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PROD_W = ENC_W + GAIN_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [ENC_W-1:0] ERR_MAX   = {1'b0, {(ENC_W-1){1'b1}}};
  localparam logic signed [ENC_W-1:0] ERR_MIN   = {1'b1, {(ENC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] DUTY_MID  = SUM_W'(2 ** (PWM_W - 1));
  localparam logic signed [SUM_W-1:0] DUTY_MAX  = SUM_W'((2 ** PWM_W) - 1);
  localparam logic [PWM_W-1:0]        DUTY_RST  = {1'b1, {(PWM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MUL   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Sweep control
  state_t                    state_q, state_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      tick;

  // Datapath pipeline registers
  logic signed [ENC_W-1:0]   err_q, err_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;

  // Outputs and status
  logic [PWM_W-1:0]          duty_q [NCH];
  logic [PWM_W-1:0]          duty_d [NCH];
  logic [NCH-1:0]            duty_stb_q, duty_stb_d;
  logic                      overrun_q, overrun_d;

  // Firmware-written configuration
  logic signed [ENC_W-1:0]   sp_q [NCH];
  logic signed [ENC_W-1:0]   sp_d [NCH];
  logic [GAIN_W-1:0]         kp_q [NCH];
  logic [GAIN_W-1:0]         kp_d [NCH];

  // Datapath combinational values
  logic signed [ENC_W-1:0]   enc_a [NCH];
  logic signed [ENC_W-1:0]   sp_sel, enc_sel;
  logic [GAIN_W-1:0]         kp_sel;
  logic signed [ENC_W:0]     diff;
  logic signed [ENC_W-1:0]   err_sat;
  logic signed [PROD_W-1:0]  err_ext, kp_ext, prod_next;
  logic signed [PROD_W-1:0]  shifted;
  logic signed [SUM_W-1:0]   sum;
  logic [PWM_W-1:0]          duty_next;

  // Update timer: counts while enabled, held at zero otherwise; tick on the last count
  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == TW'(PERIOD - 1)) begin
      tick    = 1'b1;
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Config register writes; unused addresses match no slot and fall through
  always_comb begin
    sp_d = sp_q;
    kp_d = kp_q;
    if (cfg_we) begin
      for (int k = 0; k < NCH; k++) begin
        if (cfg_addr == 4'(2 * k)) begin
          sp_d[k] = cfg_wdata[ENC_W-1:0];
        end
        if ((cfg_addr == 4'(2 * k + 1)) && (cfg_addr != 4'hF)) begin
          kp_d[k] = cfg_wdata[GAIN_W-1:0];
        end
      end
    end
  end

  // Sticky overrun: a tick outside IDLE is dropped and flagged; set beats clear
  always_comb begin
    overrun_d = overrun_q;
    if (cfg_we && (cfg_addr == 4'hF)) begin
      overrun_d = 1'b0;
    end
    if (tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Split the packed encoder bus into per-channel signed counts
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      enc_a[k] = enc_count[k*ENC_W +: ENC_W];
    end
  end

  // Shared datapath: saturating subtract, multiply, shift, offset, clamp
  always_comb begin
    sp_sel  = sp_q[ch_q];
    enc_sel = enc_a[ch_q];
    kp_sel  = kp_q[ch_q];

    // One extra bit holds any difference of two ENC_W values exactly.
    diff = {sp_sel[ENC_W-1], sp_sel} - {enc_sel[ENC_W-1], enc_sel};
    if (diff[ENC_W] != diff[ENC_W-1]) begin
      err_sat = diff[ENC_W] ? ERR_MIN : ERR_MAX;
    end else begin
      err_sat = diff[ENC_W-1:0];
    end

    // kp is an unsigned gain, so it is zero-extended before the signed multiply.
    err_ext   = PROD_W'(err_q);
    kp_ext    = PROD_W'({1'b0, kp_sel});
    prod_next = err_ext * kp_ext;

    // Arithmetic shift rounds toward minus infinity, then recentre on the midpoint.
    shifted = prod_q >>> SHIFT;
    sum     = SUM_W'(shifted) + DUTY_MID;
    if (sum[SUM_W-1]) begin
      duty_next = '0;
    end else if (sum > DUTY_MAX) begin
      duty_next = '1;
    end else begin
      duty_next = sum[PWM_W-1:0];
    end
  end

  // Sweep FSM: next state, channel index and pipeline register loads
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    err_d      = err_q;
    prod_d     = prod_q;
    duty_d     = duty_q;
    duty_stb_d = '0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        err_d   = err_sat;
        state_d = S_MUL;
      end
      S_MUL: begin
        prod_d  = prod_next;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        duty_d[ch_q]     = duty_next;
        duty_stb_d[ch_q] = 1'b1;
        if (ch_q == CW'(NCH - 1)) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers; reset parks every motor at the midpoint duty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      timer_q    <= '0;
      err_q      <= '0;
      prod_q     <= '0;
      duty_stb_q <= '0;
      overrun_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        duty_q[k] <= DUTY_RST;
        sp_q[k]   <= '0;
        kp_q[k]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      prod_q     <= prod_d;
      duty_stb_q <= duty_stb_d;
      overrun_q  <= overrun_d;
      for (int k = 0; k < NCH; k++) begin
        duty_q[k] <= duty_d[k];
        sp_q[k]   <= sp_d[k];
        kp_q[k]   <= kp_d[k];
      end
    end
  end

  // Pack per-channel duties onto the output bus
  always_comb begin
    duty = '0;
    for (int k = 0; k < NCH; k++) begin
      duty[k*PWM_W +: PWM_W] = duty_q[k];
    end
  end

  assign duty_stb = duty_stb_q;
  assign busy     = (state_q != S_IDLE);
  assign overrun  = overrun_q;

endmodule
